rcv_fifo_buffer: RTL and testbench

//  3-row receive FIFO between the USB RX byte stage (writer) and the AHB-side packet reader.

---
 rtl/rcv_fifo_pkg.sv | 18 +
 rtl/rcv_fifo_ptr.sv | 27 ++
 rtl/rcv_fifo_buffer.sv | 88 ++++++++
 tb/tb_rcv_fifo_buffer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rcv_fifo_pkg.sv
// Shared types and constants for the 3-row USB receive FIFO.
// Row pointers run 0..2 and carry a wrap toggle for full/empty disambiguation.
package rcv_fifo_pkg;

  localparam int FIFO_ROWS = 3;
  localparam int PTR_W     = 2;
  localparam logic [PTR_W-1:0] PTR_MAX = 2'd2;

  typedef struct packed {
    logic             tog;
    logic [PTR_W-1:0] ptr;
  } fifo_ptr_t;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/rcv_fifo_ptr.sv
// Row counter 0->1->2->0 with a toggle that flips on each wrap.
// Used for both the head (read) and tail (write) side of the FIFO.
module rcv_fifo_ptr
  import rcv_fifo_pkg::*;
(
  input  logic      clk,
  input  logic      n_rst,
  input  logic      step,
  input  logic      clr,
  output fifo_ptr_t value
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (step) begin
      value.ptr <= ptr_next(value.ptr);
      if (value.ptr == PTR_MAX) value.tog <= ~value.tog;
    end
  end

  // Row index 3 has no storage behind it and must never be reached.
  ptr_in_range: assert property (@(posedge clk) disable iff (!n_rst) value.ptr != 2'd3);

endmodule

// File: rtl/rcv_fifo_buffer.sv
// 3-row receive FIFO between the USB RX byte stage and the AHB packet reader.
// Registered read data, pointer+toggle full/empty, sticky overflow/underflow flags.
module rcv_fifo_buffer
  import rcv_fifo_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              flush,
  input  logic              err_clr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count,
  output logic              overflow_err,
  output logic              underflow_err
);

  fifo_ptr_t         head_q;
  fifo_ptr_t         tail_q;
  logic [DATA_W-1:0] mem [FIFO_ROWS];
  logic              push_ok;
  logic              pop_ok;
  logic [2:0]        count_w;

  // Status is derived from registered pointers only, so a pop never frees a slot
  // for a push in the same cycle.
  assign empty   = (head_q.ptr == tail_q.ptr) && (head_q.tog == tail_q.tog);
  assign full    = (head_q.ptr == tail_q.ptr) && (head_q.tog != tail_q.tog);
  assign push_ok = wr_en && !full && !flush;
  assign pop_ok  = rd_en && !empty && !flush;

  always_comb begin
    count_w = {1'b0, tail_q.ptr} - {1'b0, head_q.ptr};
    if (head_q.tog != tail_q.tog) count_w = count_w + 3'(FIFO_ROWS);
  end
  assign count = count_w[1:0];

  rcv_fifo_ptr u_tail (
    .clk   (clk),
    .n_rst (n_rst),
    .step  (push_ok),
    .clr   (flush),
    .value (tail_q)
  );

  rcv_fifo_ptr u_head (
    .clk   (clk),
    .n_rst (n_rst),
    .step  (pop_ok),
    .clr   (flush),
    .value (head_q)
  );

  always_ff @(posedge clk) begin
    if (push_ok) mem[tail_q.ptr] <= wr_data;
  end

  // Read stage: rd_data holds its last popped row until the next pop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop_ok;
      if (pop_ok) rd_data <= mem[head_q.ptr];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (flush) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      overflow_err  <= (wr_en && full)  || (overflow_err  && !err_clr);
      underflow_err <= (rd_en && empty) || (underflow_err && !err_clr);
    end
  end

endmodule

// File: tb/tb_rcv_fifo_buffer.sv
// Directed bench for rcv_fifo_buffer: fill/drain, errors, simultaneous access,
// flush, pointer wrap and asynchronous reset in the middle of traffic.
module tb_rcv_fifo_buffer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic       flush;
  logic       err_clr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic [1:0] count;
  logic       overflow_err;
  logic       underflow_err;

  int checks = 0;
  int errors = 0;

  rcv_fifo_buffer #(.DATA_W(8)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .rd_en         (rd_en),
    .flush         (flush),
    .err_clr       (err_clr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic e, input logic f, input logic [1:0] c);
    chk({tag, ".empty"}, 16'(empty), 16'(e));
    chk({tag, ".full"},  16'(full),  16'(f));
    chk({tag, ".count"}, 16'(count), 16'(c));
  endtask

  initial begin
    n_rst = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_status("reset", 1'b1, 1'b0, 2'd0);
    chk("reset.rd_valid", 16'(rd_valid), 16'd0);
    chk("reset.rd_data", 16'(rd_data), 16'h00);
    chk("reset.ovf", 16'(overflow_err), 16'd0);
    chk("reset.unf", 16'(underflow_err), 16'd0);
    n_rst = 1'b1;
    tick();
    chk_status("idle", 1'b1, 1'b0, 2'd0);

    // Fill to three rows
    wr_en = 1'b1; wr_data = 8'hA1; tick();
    chk_status("push1", 1'b0, 1'b0, 2'd1);
    wr_data = 8'hB2; tick();
    chk_status("push2", 1'b0, 1'b0, 2'd2);
    wr_data = 8'hC3; tick();
    chk_status("push3", 1'b0, 1'b1, 2'd3);
    wr_data = 8'hD4; tick();
    chk_status("push_full", 1'b0, 1'b1, 2'd3);
    chk("push_full.ovf", 16'(overflow_err), 16'd1);
    wr_en = 1'b0;

    // Drain in order
    rd_en = 1'b1; tick();
    chk("pop1.data", 16'(rd_data), 16'hA1);
    chk("pop1.valid", 16'(rd_valid), 16'd1);
    chk("pop1.count", 16'(count), 16'd2);
    tick();
    chk("pop2.data", 16'(rd_data), 16'hB2);
    chk("pop2.valid", 16'(rd_valid), 16'd1);
    tick();
    chk("pop3.data", 16'(rd_data), 16'hC3);
    chk("pop3.valid", 16'(rd_valid), 16'd1);
    chk_status("pop3", 1'b1, 1'b0, 2'd0);
    tick();
    chk("pop_empty.unf", 16'(underflow_err), 16'd1);
    chk("pop_empty.valid", 16'(rd_valid), 16'd0);
    chk("pop_empty.data", 16'(rd_data), 16'hC3);
    chk("ovf_sticky", 16'(overflow_err), 16'd1);

    // err_clr coinciding with a fresh underflow: set wins
    err_clr = 1'b1; tick();
    chk("clr_vs_set.unf", 16'(underflow_err), 16'd1);
    chk("clr_vs_set.ovf", 16'(overflow_err), 16'd0);
    rd_en = 1'b0; tick();
    chk("clr.unf", 16'(underflow_err), 16'd0);
    err_clr = 1'b0;

    // Empty with simultaneous push and pop: push only
    wr_en = 1'b1; wr_data = 8'hF0; rd_en = 1'b1; tick();
    chk_status("empty_wr_rd", 1'b0, 1'b0, 2'd1);
    chk("empty_wr_rd.unf", 16'(underflow_err), 16'd1);
    chk("empty_wr_rd.valid", 16'(rd_valid), 16'd0);
    rd_en = 1'b0;
    wr_data = 8'h11; tick();
    wr_data = 8'h22; tick();
    chk_status("refill", 1'b0, 1'b1, 2'd3);

    // Full with simultaneous push and pop: pop only
    wr_data = 8'h33; rd_en = 1'b1; tick();
    chk_status("full_wr_rd", 1'b0, 1'b0, 2'd2);
    chk("full_wr_rd.ovf", 16'(overflow_err), 16'd1);
    chk("full_wr_rd.data", 16'(rd_data), 16'hF0);
    chk("full_wr_rd.valid", 16'(rd_valid), 16'd1);

    // Flush at count 2 overrides the pending push and pop
    flush = 1'b1; wr_data = 8'h44; tick();
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk_status("flush", 1'b1, 1'b0, 2'd0);
    chk("flush.ovf", 16'(overflow_err), 16'd0);
    chk("flush.unf", 16'(underflow_err), 16'd0);
    chk("flush.valid", 16'(rd_valid), 16'd0);
    chk("flush.data", 16'(rd_data), 16'hF0);

    // Wrap: one row preloaded, then 8 push/pop pairs
    wr_en = 1'b1; wr_data = 8'h10; tick();
    chk("wrap.pre_count", 16'(count), 16'd1);
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_data = 8'h11 + 8'(i);
      tick();
      chk($sformatf("wrap%0d.data", i), 16'(rd_data), 16'(8'h10 + 8'(i)));
      chk($sformatf("wrap%0d.valid", i), 16'(rd_valid), 16'd1);
      chk($sformatf("wrap%0d.count", i), 16'(count), 16'd1);
    end
    // Tail took 9 steps from row 0 (3 wraps), head took 8 (2 wraps).
    chk("wrap.tail_ptr", 16'(dut.tail_q.ptr), 16'd0);
    chk("wrap.tail_tog", 16'(dut.tail_q.tog), 16'd1);
    chk("wrap.head_ptr", 16'(dut.head_q.ptr), 16'd2);
    chk("wrap.head_tog", 16'(dut.head_q.tog), 16'd0);
    wr_en = 1'b0; tick();
    chk("wrap.last_data", 16'(rd_data), 16'h18);
    chk_status("wrap.end", 1'b1, 1'b0, 2'd0);
    rd_en = 1'b0;

    // Asynchronous reset in the middle of traffic
    wr_en = 1'b1; wr_data = 8'h5A; tick();
    wr_data = 8'h6B; rd_en = 1'b1; tick();
    chk("burst.data", 16'(rd_data), 16'h5A);
    chk("burst.valid", 16'(rd_valid), 16'd1);
    wr_data = 8'h7C;
    #2 n_rst = 1'b0;
    #1;
    chk_status("async_rst", 1'b1, 1'b0, 2'd0);
    chk("async_rst.valid", 16'(rd_valid), 16'd0);
    chk("async_rst.data", 16'(rd_data), 16'h00);
    wr_en = 1'b0; rd_en = 1'b0;
    #3 n_rst = 1'b1;
    tick();
    chk("post_rst.valid", 16'(rd_valid), 16'd0);
    chk_status("post_rst", 1'b1, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
